// File: rtl/peak_reg_dbg_ctrl.sv
// peak_reg_dbg_ctrl -- debug bridge that halts the core and then reads or writes
// a burst of general-purpose registers through the register-file debug port.
//
// Ports:
//   CLK, RST                        clock (rising edge), asynchronous active-high reset
//   REQ_VALID/REQ_READY             command handshake; REQ_WR selects write (1) or read (0)
//   REQ_ADDR, REQ_LEN               first GPR index, burst length minus one
//   WDATA_VALID/WDATA_READY/WDATA   write-word stream into the bridge
//   RDATA_VALID/RDATA_READY/RDATA   read-word stream out of the bridge
//   HALT_REQ, HALT_ACK              core halt request / level acknowledge
//   AR_EN, AR_WR, AR_AD, AR_DI      register-file debug port strobes, address, write data
//   AR_DO                           register-file read data, valid one cycle after AR_EN
//   BUSY, DONE, DONE_ERR            command in progress, completion pulse, halt timeout flag
//
// Every output is a register that reflects the state being entered, so the
// outputs of a state are driven on the transition into it.
module peak_reg_dbg_ctrl #(
  parameter logic [7:0]  AR_REGADDR   = 8'h10,
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WR,
  input  logic [4:0]  REQ_ADDR,
  input  logic [4:0]  REQ_LEN,
  input  logic        WDATA_VALID,
  output logic        WDATA_READY,
  input  logic [31:0] WDATA,
  output logic        RDATA_VALID,
  input  logic        RDATA_READY,
  output logic [31:0] RDATA,
  output logic        HALT_REQ,
  input  logic        HALT_ACK,
  output logic        AR_EN,
  output logic        AR_WR,
  output logic [15:0] AR_AD,
  output logic [31:0] AR_DI,
  input  logic [31:0] AR_DO,
  output logic        BUSY,
  output logic        DONE,
  output logic        DONE_ERR
);

  typedef enum logic [2:0] {
    IDLE, HALT, WR_WAIT, WR_DO, RD_ISSUE, RD_CAP, RD_SEND, RELEASE
  } state_t;

  // Last halt-wait cycle; leaving HALT on it keeps HALT_REQ high for HALT_TIMEOUT cycles.
  localparam logic [7:0] HALT_LAST = 8'(HALT_TIMEOUT - 1);

  state_t      state;
  logic        wr;        // latched command direction
  logic [4:0]  addr;      // current GPR index, wraps modulo 32
  logic [4:0]  cnt;       // words remaining after the current one
  logic [7:0]  halt_cnt;  // cycles spent waiting for HALT_ACK
  logic        err;       // halt timeout seen for this command

  // Always targets the task-0 bank of the register-file page.
  function automatic logic [15:0] ar_addr(input logic [4:0] a);
    return {AR_REGADDR, 3'b000, a};
  endfunction

  // NOTE: asynchronous reset puts every output at 0 in the same cycle RST rises,
  // so an aborted burst never leaves a stray strobe or DONE pulse behind.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      wr          <= 1'b0;
      addr        <= '0;
      cnt         <= '0;
      halt_cnt    <= '0;
      err         <= 1'b0;
      REQ_READY   <= 1'b0;
      WDATA_READY <= 1'b0;
      RDATA_VALID <= 1'b0;
      RDATA       <= '0;
      HALT_REQ    <= 1'b0;
      AR_EN       <= 1'b0;
      AR_WR       <= 1'b0;
      AR_AD       <= '0;
      AR_DI       <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      DONE_ERR    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere in this block; these defaults
      // are overridden below only for the state being entered or held.
      REQ_READY   <= 1'b0;
      WDATA_READY <= 1'b0;
      RDATA_VALID <= 1'b0;
      AR_EN       <= 1'b0;
      AR_WR       <= 1'b0;
      AR_AD       <= '0;
      AR_DI       <= '0;
      DONE        <= 1'b0;
      DONE_ERR    <= 1'b0;

      case (state)
        IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            wr       <= REQ_WR;
            addr     <= REQ_ADDR;
            cnt      <= REQ_LEN;
            halt_cnt <= '0;
            HALT_REQ <= 1'b1;
            BUSY     <= 1'b1;
            state    <= HALT;
          end else begin
            REQ_READY <= 1'b1;
          end
        end

        HALT: begin
          if (HALT_ACK) begin
            if (wr) begin
              WDATA_READY <= 1'b1;
              state       <= WR_WAIT;
            end else begin
              AR_EN <= 1'b1;
              AR_AD <= ar_addr(addr);
              state <= RD_ISSUE;
            end
          end else if (halt_cnt == HALT_LAST) begin
            err      <= 1'b1;
            HALT_REQ <= 1'b0;
            DONE     <= 1'b1;
            DONE_ERR <= 1'b1;
            state    <= RELEASE;
          end else begin
            halt_cnt <= halt_cnt + 8'd1;
          end
        end

        WR_WAIT: begin
          if (WDATA_VALID) begin
            AR_EN <= 1'b1;
            AR_WR <= 1'b1;
            AR_AD <= ar_addr(addr);
            AR_DI <= WDATA;
            state <= WR_DO;
          end else begin
            WDATA_READY <= 1'b1;
          end
        end

        WR_DO: begin
          if (cnt == 5'd0) begin
            HALT_REQ <= 1'b0;
            DONE     <= 1'b1;
            DONE_ERR <= err;
            state    <= RELEASE;
          end else begin
            cnt         <= cnt - 5'd1;
            addr        <= addr + 5'd1;
            WDATA_READY <= 1'b1;
            state       <= WR_WAIT;
          end
        end

        RD_ISSUE: state <= RD_CAP;

        // AR_DO is valid in the cycle after the AR_EN strobe.
        RD_CAP: begin
          RDATA       <= AR_DO;
          RDATA_VALID <= 1'b1;
          state       <= RD_SEND;
        end

        RD_SEND: begin
          if (!RDATA_READY) begin
            RDATA_VALID <= 1'b1;
          end else if (cnt == 5'd0) begin
            HALT_REQ <= 1'b0;
            DONE     <= 1'b1;
            DONE_ERR <= err;
            state    <= RELEASE;
          end else begin
            cnt   <= cnt - 5'd1;
            addr  <= addr + 5'd1;
            AR_EN <= 1'b1;
            AR_AD <= ar_addr(addr + 5'd1);
            state <= RD_ISSUE;
          end
        end

        RELEASE: begin
          err       <= 1'b0;
          BUSY      <= 1'b0;
          REQ_READY <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_reg_dbg_ctrl.sv
// Directed testbench for peak_reg_dbg_ctrl: a small register-file model sits on
// the AR port (GPR 0 reads as zero, one-cycle read latency) and each scenario
// compares DUT outputs and the logged AR traffic with hand-computed values.
module tb_peak_reg_dbg_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0, REQ_READY, REQ_WR = 1'b0;
  logic [4:0]  REQ_ADDR = '0, REQ_LEN = '0;
  logic        WDATA_VALID = 1'b0, WDATA_READY;
  logic [31:0] WDATA = '0;
  logic        RDATA_VALID, RDATA_READY = 1'b0;
  logic [31:0] RDATA;
  logic        HALT_REQ, HALT_ACK = 1'b0;
  logic        AR_EN, AR_WR;
  logic [15:0] AR_AD;
  logic [31:0] AR_DI;
  logic [31:0] AR_DO = '0;
  logic        BUSY, DONE, DONE_ERR;

  peak_reg_dbg_ctrl #(.AR_REGADDR(8'h10), .HALT_TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .WDATA_VALID(WDATA_VALID), .WDATA_READY(WDATA_READY), .WDATA(WDATA),
    .RDATA_VALID(RDATA_VALID), .RDATA_READY(RDATA_READY), .RDATA(RDATA),
    .HALT_REQ(HALT_REQ), .HALT_ACK(HALT_ACK),
    .AR_EN(AR_EN), .AR_WR(AR_WR), .AR_AD(AR_AD), .AR_DI(AR_DI), .AR_DO(AR_DO),
    .BUSY(BUSY), .DONE(DONE), .DONE_ERR(DONE_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Register-file model and AR traffic log.
  logic [31:0] gpr [32] = '{default: 32'h0};
  logic [15:0] wr_ad [$];
  logic [31:0] wr_di [$];
  logic [15:0] rd_ad [$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, acc_cnt = 0, acc_cyc = 0, ar_en_cnt = 0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (AR_EN) ar_en_cnt <= ar_en_cnt + 1;
    if (AR_EN && AR_WR) begin
      wr_ad.push_back(AR_AD);
      wr_di.push_back(AR_DI);
      if (AR_AD[15:8] == 8'h10 && AR_AD[4:0] != 5'd0) gpr[AR_AD[4:0]] <= AR_DI;
    end
    if (AR_EN && !AR_WR) begin
      rd_ad.push_back(AR_AD);
      AR_DO <= (AR_AD[4:0] == 5'd0) ? 32'h0 : gpr[AR_AD[4:0]];
    end
    if (DONE) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (REQ_VALID && REQ_READY) begin
      acc_cnt <= acc_cnt + 1;
      acc_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return REQ_READY;
      1:       return WDATA_READY;
      2:       return RDATA_VALID;
      default: return DONE;
    endcase
  endfunction

  task automatic wait_on(input int which, input string tag);
    int n = 0;
    while (!sig(which) && n < 400) begin
      tick();
      n++;
    end
    check(tag, 32'(sig(which)), 32'd1);
  endtask

  task automatic send_cmd(input logic wr, input logic [4:0] addr, input logic [4:0] len);
    REQ_WR = wr; REQ_ADDR = addr; REQ_LEN = len; REQ_VALID = 1'b1;
    wait_on(0, "req_ready");
    tick();
    REQ_VALID = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] d);
    wait_on(1, "wdata_ready");
    WDATA = d; WDATA_VALID = 1'b1;
    tick();
    WDATA_VALID = 1'b0;
  endtask

  task automatic read_word(input int stall, input logic [31:0] exp, input string tag);
    wait_on(2, {tag, "_rvalid"});
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(RDATA_VALID), 32'd1);
      check({tag, "_hold_data"}, RDATA, exp);
    end
    check(tag, RDATA, exp);
    RDATA_READY = 1'b1;
    tick();
    RDATA_READY = 1'b0;
  endtask

  task automatic finish_cmd(input logic exp_err, input string tag);
    wait_on(3, {tag, "_done"});
    check({tag, "_done_err"}, 32'(DONE_ERR), 32'(exp_err));
    check({tag, "_halt_req_low"}, 32'(HALT_REQ), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    check({tag, "_ready_after"}, 32'(REQ_READY), 32'd1);
  endtask

  initial begin
    automatic int base;
    automatic int n;
    automatic int dcnt;
    automatic int a0;
    automatic logic [15:0] exp_ad [4] = '{16'h101E, 16'h101F, 16'h1000, 16'h1001};
    automatic logic [31:0] exp_rd [4] = '{32'd1, 32'd2, 32'd0, 32'd4};

    // Reset state.
    #12;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_halt_req", 32'(HALT_REQ), 32'd0);
    check("rst_ar_en", 32'(AR_EN), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_rvalid", 32'(RDATA_VALID), 32'd0);
    @(negedge CLK) RST = 1'b0;
    tick();
    check("idle_ready", 32'(REQ_READY), 32'd1);
    check("idle_busy", 32'(BUSY), 32'd0);

    // Single write, HALT_ACK three cycles late.
    base = ar_en_cnt;
    send_cmd(1'b1, 5'd5, 5'd0);
    check("w1_halt_req", 32'(HALT_REQ), 32'd1);
    check("w1_busy", 32'(BUSY), 32'd1);
    check("w1_ready_low", 32'(REQ_READY), 32'd0);
    repeat (3) tick();
    check("w1_no_ar_before_ack", 32'(ar_en_cnt - base), 32'd0);
    HALT_ACK = 1'b1;
    write_word(32'hDEADBEEF);
    finish_cmd(1'b0, "w1");
    check("w1_nwrites", 32'(wr_ad.size()), 32'd1);
    check("w1_ad", 32'(wr_ad[0]), 32'h1005);
    check("w1_di", wr_di[0], 32'hDEADBEEF);
    check("w1_ar_en_cycles", 32'(ar_en_cnt - base), 32'd1);

    // Read back with four stall cycles.
    base = ar_en_cnt;
    send_cmd(1'b0, 5'd5, 5'd0);
    read_word(4, 32'hDEADBEEF, "r1");
    finish_cmd(1'b0, "r1");
    check("r1_ar_en_cycles", 32'(ar_en_cnt - base), 32'd1);
    check("r1_ad", 32'(rd_ad[0]), 32'h1005);

    // Wrapping burst 30,31,0,1 then read back (GPR 0 reads zero).
    wr_ad.delete(); wr_di.delete(); rd_ad.delete();
    send_cmd(1'b1, 5'd30, 5'd3);
    for (int i = 0; i < 4; i++) write_word(32'(i + 1));
    finish_cmd(1'b0, "wrap_w");
    check("wrap_nwrites", 32'(wr_ad.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_ad%0d", i), 32'(wr_ad[i]), 32'(exp_ad[i]));
      check($sformatf("wrap_di%0d", i), wr_di[i], 32'(i + 1));
    end
    send_cmd(1'b0, 5'd30, 5'd3);
    for (int i = 0; i < 4; i++) read_word(0, exp_rd[i], $sformatf("wrap_rd%0d", i));
    finish_cmd(1'b0, "wrap_r");
    check("wrap_rd_ad3", 32'(rd_ad[3]), 32'h1001);

    // Back-to-back: REQ_VALID held high across two commands.
    REQ_WR = 1'b1; REQ_ADDR = 5'd7; REQ_LEN = 5'd0; REQ_VALID = 1'b1;
    wait_on(0, "b2b_ready1");
    tick();
    write_word(32'hA5A50007);
    wait_on(3, "b2b_done1");
    REQ_WR = 1'b0;
    a0 = acc_cnt;
    n = 0;
    while (acc_cnt == a0 && n < 10) begin
      tick();
      n++;
    end
    REQ_VALID = 1'b0;
    check("b2b_accepted", 32'(acc_cnt - a0), 32'd1);
    check("b2b_gap", 32'(acc_cyc - done_cyc), 32'd1);
    read_word(0, 32'hA5A50007, "b2b_rd");
    finish_cmd(1'b0, "b2b");

    // Halt timeout: no AR access, HALT_REQ high 255 cycles, DONE with error.
    HALT_ACK = 1'b0;
    base = ar_en_cnt;
    send_cmd(1'b1, 5'd3, 5'd0);
    n = 0;
    while (HALT_REQ && n < 400) begin
      n++;
      tick();
    end
    check("to_halt_cycles", 32'(n), 32'd255);
    check("to_done", 32'(DONE), 32'd1);
    check("to_done_err", 32'(DONE_ERR), 32'd1);
    check("to_no_ar", 32'(ar_en_cnt - base), 32'd0);
    tick();
    check("to_ready_next", 32'(REQ_READY), 32'd1);
    check("to_done_pulse", 32'(DONE), 32'd0);
    check("to_err_cleared", 32'(DONE_ERR), 32'd0);

    // Reset during RD_SEND of an 8-word read starting at GPR 5.
    HALT_ACK = 1'b1;
    dcnt = done_cnt;
    send_cmd(1'b0, 5'd5, 5'd7);
    read_word(0, 32'hDEADBEEF, "rst_w0");
    read_word(0, 32'h0, "rst_w1");
    wait_on(2, "rst_rvalid2");
    check("rst_w2_data", RDATA, 32'hA5A50007);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_ready", 32'(REQ_READY), 32'd0);
    check("mid_rst_halt_req", 32'(HALT_REQ), 32'd0);
    check("mid_rst_busy", 32'(BUSY), 32'd0);
    check("mid_rst_rvalid", 32'(RDATA_VALID), 32'd0);
    check("mid_rst_rdata", RDATA, 32'h0);
    check("mid_rst_ar", {14'h0, AR_EN, AR_WR, AR_AD}, 32'h0);
    check("mid_rst_ar_di", AR_DI, 32'h0);
    check("mid_rst_wready", 32'(WDATA_READY), 32'd0);
    check("mid_rst_done", {30'h0, DONE, DONE_ERR}, 32'h0);
    repeat (2) tick();
    @(negedge CLK) RST = 1'b0;
    repeat (3) tick();
    check("mid_rst_no_done", 32'(done_cnt - dcnt), 32'd0);
    check("mid_rst_idle_ready", 32'(REQ_READY), 32'd1);

    // Fresh command after the abort.
    send_cmd(1'b1, 5'd9, 5'd1);
    write_word(32'h11111111);
    write_word(32'h22222222);
    finish_cmd(1'b0, "post_w");
    send_cmd(1'b0, 5'd9, 5'd1);
    read_word(0, 32'h11111111, "post_rd0");
    read_word(0, 32'h22222222, "post_rd1");
    finish_cmd(1'b0, "post_r");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
